stopwatch_seg7_driver: RTL and testbench
========================================

Name: stopwatch_seg7_driver

Overview:
Consumes the four BCD digit outputs of the stopwatch counter and drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Latches a coherent snapshot of all four digits once per refresh frame.
- Scans one digit per slot, with an anti-ghosting blank interval at the start of each slot.
- Decodes BCD to segments; lights the decimal point as the mm.ss separator.
- Sits between the stopwatch counter and the board display pins.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
ACTIVE_LOW, 1, 1 = an/seg/dp active-low (lit = 0); 0 = active-high

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
digit0  input  4  seconds ones (BCD)
digit1  input  4  seconds tens (BCD)
digit2  input  4  minutes ones (BCD)
digit3  input  4  minutes tens (BCD)
dp_en  input  1  enables decimal point on digit 2
an  output  4  anode enables; an[i] selects digit i
seg  output  7  segments {g,f,e,d,c,b,a} = seg[6:0]
dp  output  1  decimal point

Behaviour:
Reset
- Synchronous, active-high on rst.
- slot counter = 0, digit index idx = 0, shadow digits = 0.
- Outputs all off: with ACTIVE_LOW=1, an = 4'b1111, seg = 7'b1111111, dp = 1. With ACTIVE_LOW=0, all zeros.
- rst asserted mid-slot or mid-frame aborts the scan immediately; the next cycle is reset state.

Slot counter
- Width $clog2(REFRESH_DIV); counts 0 .. REFRESH_DIV-1.
- slot_end = (cnt == REFRESH_DIV-1).
- On slot_end: cnt <= 0 and idx <= idx+1, wrapping 3 -> 0.

Frame snapshot
- When slot_end and idx == 3 (frame wrap), shadow[3:0] <= digit3..digit0, all in the same cycle.
- Input changes at any other time do not affect the display until the next frame.
- The first frame after reset shows the reset shadow (0000).

Digit scan state
- idx sequence: 0 -> 1 -> 2 -> 3 -> 0.
- This is the only FSM; it advances only on slot_end.

Output register
- All outputs are registered. Values at cycle t+1 are computed from cnt, idx and shadow at cycle t (1-cycle latency).
- Blank phase (cnt < BLANK_CYCLES): all anodes off, seg off, dp off.
- Active phase: only an[idx] on.
  - seg = decode(shadow[idx]).
  - dp on iff idx == 2 and dp_en == 1. dp_en is sampled live, not snapshotted.

Decode (active-high pattern, gfedcba)
- 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
- 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
- Non-BCD 10..15 = 1000000 (dash).
- With ACTIVE_LOW=1, every pattern is inverted.

Boundaries
- BLANK_CYCLES = 0: no blank phase.
- Exactly one anode is active at any time; never two.

Optional Feature:
Macro: SEG7_LZB_EN
- Defined: leading-zero blanking. When shadow[3] == 0, the digit-3 slot keeps all anodes and segments off for the whole slot. Only digit 3 is blanked; digit 2 always displays.
- Not defined: digit 3 displays "0" normally.

Test Plan:
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
1. Reset release -> an = 1111, seg = 1111111, dp = 1; first frame scans an = 1110, 1101, 1011, 0111, each showing seg = 1000000 ("0"); each active for 3 cycles after 1 blank cycle.
2. Drive digit3..0 = 1,9,5,3 before a frame wrap -> next frame shows seg = 0110000 on an = 1110, 0010010 on 1101, 0010000 on 1011, 1111001 on 0111.
3. Change inputs to 2,2,2,2 mid-frame -> the current frame is unchanged; 2s (seg = 0100100) appear only after the 3 -> 0 wrap.
4. dp_en = 1 -> dp = 0 only while an = 1011 during its active phase; dp = 1 in all other slots and in every blank cycle.
5. digit0 = 4'hC -> seg = 0111111 (dash) on the an = 1110 slot.
6. Assert rst for 1 cycle during the active phase of slot 2 -> next cycle outputs are all off and idx restarts at 0. With SEG7_LZB_EN defined and digit3 = 0, the an = 0111 slot never asserts.

Source files
------------

// File: rtl/stopwatch_seg7_driver_if.sv
// Display bus between the stopwatch counter side and the 7-segment scan driver.
interface stopwatch_seg7_driver_if;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic       dp_en;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   // Counter side: supplies BCD digits and separator enable, observes the pins
   modport master (
      output digit0, digit1, digit2, digit3, dp_en,
      input  an, seg, dp
   );

   // Driver side: consumes digits, drives anode/segment/dp pins
   modport slave (
      input  digit0, digit1, digit2, digit3, dp_en,
      output an, seg, dp
   );
endinterface

// File: rtl/stopwatch_seg7_driver.sv
// 4-digit time-multiplexed 7-segment driver for the stopwatch (mm.ss).
// Snapshots all digits once per frame, scans one digit per slot with a
// leading blank interval, and registers every pin.
// Optional build macro: SEG7_LZB_EN blanks digit 3 while it holds zero.
module stopwatch_seg7_driver #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   stopwatch_seg7_driver_if.slave disp_io
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
   localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};

   typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} idx_e;

   idx_e             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0][3:0]  shadow_q, shadow_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             slot_end_c;
   logic             blank_c;
   logic             lzb_c;

   // BCD to active-high gfedcba; non-BCD codes show a dash
   function automatic logic [6:0] decode(input logic [3:0] bcd);
      case (bcd)
         4'd0:    decode = 7'b0111111;
         4'd1:    decode = 7'b0000110;
         4'd2:    decode = 7'b1011011;
         4'd3:    decode = 7'b1001111;
         4'd4:    decode = 7'b1100110;
         4'd5:    decode = 7'b1101101;
         4'd6:    decode = 7'b1111101;
         4'd7:    decode = 7'b0000111;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1101111;
         default: decode = 7'b1000000;
      endcase
   endfunction

   assign slot_end_c = (cnt_q == CNT_MAX);

`ifdef SEG7_LZB_EN
   // Suppress a leading zero in the minutes-tens position
   assign lzb_c = (state_q == DIG3) && (shadow_q[3] == 4'd0);
`else
   assign lzb_c = 1'b0;
`endif

   assign blank_c = (32'(cnt_q) < BLANK_CYCLES) || lzb_c;

   // State, counter, snapshot and pin registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DIG0;
         cnt_q    <= '0;
         shadow_q <= '0;
         an_q     <= AN_POL;
         seg_q    <= SEG_POL;
         dp_q     <= ACTIVE_LOW;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   // Slot timing, digit scan, frame snapshot and next pin values
   always_comb begin
      logic [3:0] an_hi;
      logic [6:0] seg_hi;
      logic       dp_hi;

      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      shadow_d = shadow_q;
      an_hi    = '0;
      seg_hi   = '0;
      dp_hi    = 1'b0;

      if (slot_end_c) begin
         cnt_d = '0;
         case (state_q)
            DIG0:    state_d = DIG1;
            DIG1:    state_d = DIG2;
            DIG2:    state_d = DIG3;
            default: begin
               state_d  = DIG0;
               shadow_d = {disp_io.digit3, disp_io.digit2, disp_io.digit1, disp_io.digit0};
            end
         endcase
      end

      if (!blank_c) begin
         an_hi[state_q] = 1'b1;
         seg_hi         = decode(shadow_q[state_q]);
         dp_hi          = (state_q == DIG2) && disp_io.dp_en;
      end

      an_d  = an_hi ^ AN_POL;
      seg_d = seg_hi ^ SEG_POL;
      dp_d  = dp_hi ^ ACTIVE_LOW;
   end

   assign disp_io.an  = an_q;
   assign disp_io.seg = seg_q;
   assign disp_io.dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_seg7_driver.sv
// Randomized bench for stopwatch_seg7_driver against a cycle-count reference model.
module tb_stopwatch_seg7_driver;

   localparam int unsigned DIV   = 4;
   localparam int unsigned BLANK = 1;

   logic clk;
   logic rst;

   stopwatch_seg7_driver_if bus ();

   stopwatch_seg7_driver #(
      .REFRESH_DIV (DIV),
      .BLANK_CYCLES(BLANK),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .disp_io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Display patterns, active-high gfedcba, indexed by digit code
   localparam logic [6:0] PAT [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
      7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

   int n_checks = 0;
   int n_fail   = 0;

   // Model: cycles elapsed since reset plus the displayed snapshot
   int         n_cyc;
   logic [3:0] sh [4];
   logic [3:0] cur [4];
   logic       cur_de;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // One clock: apply inputs, predict the registered pins, compare after the edge
   task automatic step(input logic r);
      int         slot_pos, idx;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       lit;

      rst = r;
      bus.digit0 = cur[0];
      bus.digit1 = cur[1];
      bus.digit2 = cur[2];
      bus.digit3 = cur[3];
      bus.dp_en  = cur_de;
      @(posedge clk);

      slot_pos = n_cyc % DIV;
      idx      = (n_cyc / DIV) % 4;
      lit      = !r && (slot_pos >= BLANK);
`ifdef SEG7_LZB_EN
      if (idx == 3 && sh[3] == 4'd0) lit = 1'b0;
`endif
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (lit) begin
         e_an[idx] = 1'b0;
         e_seg     = ~PAT[sh[idx]];
         e_dp      = !(idx == 2 && cur_de);
      end

      if (r) begin
         n_cyc = 0;
         for (int i = 0; i < 4; i++) sh[i] = 4'd0;
      end else begin
         if (n_cyc % (4 * DIV) == 4 * DIV - 1)
            for (int i = 0; i < 4; i++) sh[i] = cur[i];
         n_cyc++;
      end

      @(negedge clk);
      check_val("an",  32'(bus.an),  32'(e_an));
      check_val("seg", 32'(bus.seg), 32'(e_seg));
      check_val("dp",  32'(bus.dp),  32'(e_dp));
      check_val("one_anode", 32'($countones(~bus.an) <= 1), 32'd1);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0);
   endtask

   task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
      cur[3] = d3; cur[2] = d2; cur[1] = d1; cur[0] = d0;
   endtask

   initial begin
      n_cyc  = 0;
      cur_de = 1'b0;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) sh[i] = 4'd0;

      // Reset, then the first frame shows the zero snapshot
      repeat (3) step(1'b1);
      set_digits(4'd1, 4'd9, 4'd5, 4'd3);
      run(4 * DIV);

      // Second frame shows 1953; change to 2222 mid-frame
      run(2 * DIV + 2);
      set_digits(4'd2, 4'd2, 4'd2, 4'd2);
      run(2 * DIV + 4 * DIV);

      // Decimal point for a full frame, then a dash on digit 0
      cur_de = 1'b1;
      run(4 * DIV);
      set_digits(4'd1, 4'd2, 4'd3, 4'hC);
      run(8 * DIV);
      cur_de = 1'b0;

      // Reset during the active phase of slot 2
      for (int g = 0; g < 8 * DIV; g++) begin
         if ((n_cyc / DIV) % 4 == 2 && n_cyc % DIV == 2) break;
         step(1'b0);
      end
      check_val("reached_slot2", 32'((n_cyc / DIV) % 4 == 2 && n_cyc % DIV == 2), 32'd1);
      step(1'b1);
      set_digits(4'd0, 4'd4, 4'd5, 4'd6);
      run(8 * DIV);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)
            for (int d = 0; d < 4; d++) cur[d] = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) cur_de = 1'($urandom);
         if ($urandom_range(0, 3) == 0 && cur[3] != 4'd0 && $urandom_range(0, 1) == 0)
            cur[3] = 4'd0;
         step($urandom_range(0, 199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
